// File: rtl/interp_pkg.sv
// Shared types and helpers for the interpolator upsampler.
package interp_pkg;

    typedef enum logic {IDLE, EMIT} interp_state_t;

    function automatic int shift_amt(input int factor);
        return $clog2(factor);
    endfunction

    function automatic bit is_pow2_ge2(input int factor);
        return (factor >= 2) && ((factor & (factor - 1)) == 0);
    endfunction

endpackage

// File: rtl/interp_lerp.sv
// Combinational linear interpolation: prev + ((cur - prev) * phase) >>> ShiftAmt.
// Only instantiated when INTERP_LINEAR_EN is defined.
module interp_lerp #(
    parameter int Data_bits = 10,
    parameter int ShiftAmt  = 3
) (
    input  logic signed [Data_bits-1:0] prev,
    input  logic signed [Data_bits-1:0] cur,
    input  logic        [ShiftAmt-1:0]  phase,
    output logic signed [Data_bits-1:0] sample
);

    localparam int ProdBits = Data_bits + 1 + ShiftAmt;

    logic signed [Data_bits:0]  diff;
    logic signed [ProdBits-1:0] diff_ext;
    logic signed [ProdBits-1:0] phase_ext;
    logic signed [ProdBits-1:0] prod;

    assign diff      = $signed({cur[Data_bits-1], cur}) - $signed({prev[Data_bits-1], prev});
    assign diff_ext  = ProdBits'(diff);
    assign phase_ext = $signed({{(ProdBits - ShiftAmt){1'b0}}, phase});
    assign prod      = diff_ext * phase_ext;

    // The floored result lies between prev and cur, so dropping the upper bits is lossless.
    assign sample = Data_bits'(ProdBits'(prev) + (prod >>> ShiftAmt));

endmodule

// File: rtl/interpolator.sv
// Upsampler emitting Interp_factor output samples per accepted input sample.
// Sample-and-hold by default; define INTERP_LINEAR_EN for linear interpolation.
module interpolator
    import interp_pkg::*;
#(
    parameter int Interp_factor = 8,
    parameter int Data_bits     = 10
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic signed [Data_bits-1:0] data_in,
    input  logic                        data_valid_i,
    output logic                        data_ready_o,
    output logic signed [Data_bits-1:0] data_out,
    output logic                        data_valid_o,
    input  logic                        data_ready_i
);

    localparam int ShiftAmt = shift_amt(Interp_factor);
    localparam logic [ShiftAmt-1:0] LastPhase = ShiftAmt'(Interp_factor - 1);

    if (!is_pow2_ge2(Interp_factor)) begin : g_bad_factor
        $error("interpolator: Interp_factor must be a power of two and >= 2");
    end

    interp_state_t               state_q, state_d;
    logic [ShiftAmt-1:0]         phase_q, phase_d;
    logic signed [Data_bits-1:0] cur_q, cur_d;
    logic signed [Data_bits-1:0] data_out_q, data_out_d;
    logic signed [Data_bits-1:0] next_sample;
    logic                        last_phase;
    logic                        accept;
    logic                        emit;

    assign last_phase   = (phase_q == LastPhase);
    assign data_ready_o = (state_q == IDLE) || ((state_q == EMIT) && last_phase && data_ready_i);
    assign accept       = data_valid_i && data_ready_o;
    assign emit         = (state_q == EMIT) && data_ready_i;
    assign data_valid_o = (state_q == EMIT);
    assign data_out     = data_out_q;

`ifdef INTERP_LINEAR_EN
    logic signed [Data_bits-1:0] prev_q, prev_d;
    logic signed [Data_bits-1:0] lerp_prev, lerp_cur;
    logic [ShiftAmt-1:0]         lerp_phase;

    // On accept the output register is loaded with phase 0 of the new pair (old cur, data_in).
    always_comb begin
        lerp_prev  = prev_q;
        lerp_cur   = cur_q;
        lerp_phase = phase_q + ShiftAmt'(1);
        prev_d     = prev_q;
        if (accept) begin
            lerp_prev  = cur_q;
            lerp_cur   = data_in;
            lerp_phase = '0;
            prev_d     = cur_q;
        end
    end

    interp_lerp #(
        .Data_bits (Data_bits),
        .ShiftAmt  (ShiftAmt)
    ) u_lerp (
        .prev   (lerp_prev),
        .cur    (lerp_cur),
        .phase  (lerp_phase),
        .sample (next_sample)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end
`else
    assign next_sample = accept ? data_in : cur_q;
`endif

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cur_d      = cur_q;
        data_out_d = data_out_q;
        if (accept) begin
            state_d    = EMIT;
            phase_d    = '0;
            cur_d      = data_in;
            data_out_d = next_sample;
        end else if (emit) begin
            if (last_phase) begin
                state_d = IDLE;
            end else begin
                phase_d    = phase_q + ShiftAmt'(1);
                data_out_d = next_sample;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            cur_q      <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cur_q      <= cur_d;
            data_out_q <= data_out_d;
        end
    end

endmodule

// File: tb/tb_interpolator.sv
// Directed self-checking bench for interpolator (hold build; linear vectors under INTERP_LINEAR_EN).
module tb_interpolator;

    localparam int L = 8;
    localparam int D = 10;
    localparam int S = $clog2(L);

    typedef logic signed [D-1:0] burst_t [L];

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic signed [D-1:0] data_in;
    logic                data_valid_i;
    logic                data_ready_o;
    logic signed [D-1:0] data_out;
    logic                data_valid_o;
    logic                data_ready_i;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk_i = ~clk_i;

    interpolator #(
        .Interp_factor (L),
        .Data_bits     (D)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .data_in      (data_in),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .data_out     (data_out),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i)
    );

    task automatic check_output(input string tag, input logic signed [31:0] obs,
                                input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Expected burst for the pair (prev, cur); hold mode collapses to cur.
    function automatic burst_t model(input int prev, input int cur);
        burst_t r;
        int     base;
        base = prev;
`ifndef INTERP_LINEAR_EN
        base = cur;
`endif
        for (int k = 0; k < L; k++) begin
            r[k] = D'(base + (((cur - base) * k) >>> S));
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_valid"}, data_valid_o, 1'b0);
        check_output({tag, "_ready"}, data_ready_o, 1'b1);
    endtask

    // First edge is the accepting edge; next-input is presented right after it.
    task automatic run_burst(input string tag, input burst_t expv, input logic nxt_valid,
                             input logic signed [D-1:0] nxt_data);
        for (int k = 0; k < L; k++) begin
            tick();
            if (k == 0) begin
                data_valid_i = nxt_valid;
                data_in      = nxt_data;
            end
            check_output($sformatf("%s_out%0d", tag, k), data_out, expv[k]);
            check_output($sformatf("%s_valid%0d", tag, k), data_valid_o, 1'b1);
            check_output($sformatf("%s_ready%0d", tag, k), data_ready_o, (k == L - 1));
        end
    endtask

    initial begin
        burst_t exp_b;
        rst_ni       = 1'b0;
        data_valid_i = 1'b0;
        data_in      = '0;
        data_ready_i = 1'b1;

        #1;
        check_output("rst_out", data_out, 0);
        check_idle("rst");
        #12;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        check_idle("post_rst");

        $display("[TB] test 1: back-to-back bursts 5 then -3");
        data_valid_i = 1'b1;
        data_in      = 10'sd5;
        #1;
        check_output("t1_ready_idle", data_ready_o, 1'b1);
        run_burst("t1a", model(0, 5), 1'b1, -10'sd3);
        run_burst("t1b", model(5, -3), 1'b0, '0);
        tick();
        check_idle("t1_end");

        $display("[TB] test 2: back-pressure at phase 3");
        data_valid_i = 1'b1;
        data_in      = 10'sd7;
        exp_b        = model(-3, 7);
        tick();
        data_valid_i = 1'b0;
        check_output("t2_out0", data_out, exp_b[0]);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_output($sformatf("t2_out%0d", k), data_out, exp_b[k]);
        end
        data_ready_i = 1'b0;
        data_valid_i = 1'b1;
        data_in      = 10'sd99;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_output($sformatf("t2_stall_out%0d", c), data_out, exp_b[3]);
            check_output($sformatf("t2_stall_valid%0d", c), data_valid_o, 1'b1);
            check_output($sformatf("t2_stall_ready%0d", c), data_ready_o, 1'b0);
        end
        data_ready_i = 1'b1;
        data_valid_i = 1'b0;
        for (int k = 4; k < L; k++) begin
            tick();
            check_output($sformatf("t2_out%0d", k), data_out, exp_b[k]);
            check_output($sformatf("t2_ready%0d", k), data_ready_o, (k == L - 1));
        end
        tick();
        check_idle("t2_end");

        $display("[TB] test 3: single sample then input gap");
        data_valid_i = 1'b1;
        data_in      = 10'sd20;
        run_burst("t3", model(7, 20), 1'b0, '0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check_idle($sformatf("t3_gap%0d", c));
        end
        data_ready_i = 1'b0;
        #1;
        check_output("t3_ready_ignores_ready_i", data_ready_o, 1'b1);
        data_ready_i = 1'b1;

        $display("[TB] test 6: async reset mid-burst");
        data_valid_i = 1'b1;
        data_in      = 10'sd40;
        exp_b        = model(20, 40);
        tick();
        data_valid_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_output($sformatf("t6_out%0d", k), data_out, exp_b[k]);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        check_output("t6_rst_out", data_out, 0);
        check_idle("t6_rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            check_idle($sformatf("t6_release%0d", c));
        end
        data_valid_i = 1'b1;
        data_in      = 10'sd16;
        run_burst("t6_ramp", model(0, 16), 1'b0, '0);
        tick();
        check_idle("t6_end");

`ifdef INTERP_LINEAR_EN
        $display("[TB] test 4: linear ramps");
        data_valid_i = 1'b1;
        data_in      = 10'sd32;
        exp_b = '{10'sd16, 10'sd18, 10'sd20, 10'sd22, 10'sd24, 10'sd26, 10'sd28, 10'sd30};
        run_burst("t4_32", exp_b, 1'b1, 10'sd511);
        run_burst("t4_511", model(32, 511), 1'b1, 10'sd0);
        exp_b = '{10'sd511, 10'sd447, 10'sd383, 10'sd319, 10'sd255, 10'sd191, 10'sd127, 10'sd63};
        run_burst("t4_0", exp_b, 1'b1, -10'sd512);

        $display("[TB] test 5: linear extremes");
        run_burst("t5_m512", model(0, -512), 1'b1, 10'sd511);
        exp_b = '{-10'sd512, -10'sd385, -10'sd257, -10'sd129, -10'sd1, 10'sd127, 10'sd255, 10'sd383};
        run_burst("t5_511", exp_b, 1'b0, '0);
        tick();
        check_idle("t5_end");
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
